// File: rtl/width_16to8_if.sv
// Word-in / byte-out handshake bundle for the 16-to-8 serialiser.
// master = upstream/downstream environment, slave = the serialiser itself.
interface width_16to8_if;
  logic        valid_in;
  logic [15:0] data_in;
  logic        ready_in;
  logic        valid_out;
  logic [7:0]  data_out;
  logic        ready_out;

  modport master (
    output valid_in,
    output data_in,
    output ready_out,
    input  ready_in,
    input  valid_out,
    input  data_out
  );

  modport slave (
    input  valid_in,
    input  data_in,
    input  ready_out,
    output ready_in,
    output valid_out,
    output data_out
  );
endinterface

// File: rtl/width_16to8.sv
// 16-bit to 8-bit serialiser: one word per input handshake, two byte beats out at full rate.
// Optional byte transfer counter enabled by defining WIDTH_16TO8_BYTE_CNT_EN.
module width_16to8 #(
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  width_16to8_if.slave bus
`ifdef WIDTH_16TO8_BYTE_CNT_EN
  ,
  output logic [15:0]  byte_cnt
`endif
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] FIRST  = 2'b01;
  localparam logic [1:0] SECOND = 2'b10;

  logic [1:0] state;
  logic [7:0] second_reg;
  logic [7:0] data_q;
  logic       valid_q;
  logic [7:0] first_byte;
  logic [7:0] second_byte;
  logic       ready;
  logic       in_xfer;
  logic       out_xfer;

  assign first_byte  = (MSB_FIRST != 0) ? bus.data_in[15:8] : bus.data_in[7:0];
  assign second_byte = (MSB_FIRST != 0) ? bus.data_in[7:0]  : bus.data_in[15:8];

  // The only combinational path through the block is ready_out -> ready_in (in SECOND).
  assign ready = !rst_n && ((state == IDLE) || ((state == SECOND) && bus.ready_out));

  assign in_xfer  = bus.valid_in && ready;
  assign out_xfer = valid_q && bus.ready_out;

  assign bus.ready_in  = ready;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      valid_q    <= 1'b0;
      data_q     <= 8'h00;
      second_reg <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_xfer) begin
            data_q     <= first_byte;
            second_reg <= second_byte;
            valid_q    <= 1'b1;
            state      <= FIRST;
          end
        end
        FIRST: begin
          if (bus.ready_out) begin
            data_q <= second_reg;
            state  <= SECOND;
          end
        end
        SECOND: begin
          // Reloading straight from SECOND is what keeps back-to-back words gap-free.
          if (bus.ready_out) begin
            if (bus.valid_in) begin
              data_q     <= first_byte;
              second_reg <= second_byte;
              valid_q    <= 1'b1;
              state      <= FIRST;
            end else begin
              valid_q <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef WIDTH_16TO8_BYTE_CNT_EN
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      byte_cnt <= 16'h0000;
    end else if (out_xfer) begin
      byte_cnt <= byte_cnt + 16'h0001;
    end
  end
`endif

  // A stalled byte must stay exactly as presented until the consumer takes it.
  assert property (@(posedge clk) disable iff (rst_n)
    (valid_q && !bus.ready_out) |=> (valid_q && $stable(data_q)));

  assert property (@(posedge clk) disable iff (rst_n) state != 2'b11);

  assert property (@(posedge clk) disable iff (rst_n)
    in_xfer |-> !(state == FIRST));

endmodule

// File: tb/tb_width_16to8.sv
// Self-checking bench for width_16to8: byte-queue reference model plus directed literal vectors.
// Exercises the byte counter only when WIDTH_16TO8_BYTE_CNT_EN is defined.
module tb_width_16to8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  width_16to8_if bus_msb ();
  width_16to8_if bus_lsb ();

`ifdef WIDTH_16TO8_BYTE_CNT_EN
  logic [15:0] cnt_msb;
  logic [15:0] cnt_lsb;
`endif

  width_16to8 #(.MSB_FIRST(1)) dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_msb)
`ifdef WIDTH_16TO8_BYTE_CNT_EN
    ,
    .byte_cnt (cnt_msb)
`endif
  );

  width_16to8 #(.MSB_FIRST(0)) dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_lsb)
`ifdef WIDTH_16TO8_BYTE_CNT_EN
    ,
    .byte_cnt (cnt_lsb)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes still owed to the consumer, oldest first.
  logic [7:0]  exp_q[$];
  logic [7:0]  last_byte = 8'h00;
  logic [15:0] exp_cnt   = 16'h0000;

  function automatic logic model_ready();
    return !rst_n && ((exp_q.size() == 0) || ((exp_q.size() == 1) && bus_msb.ready_out));
  endfunction

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      exp_q.delete();
      last_byte <= 8'h00;
      exp_cnt   <= 16'h0000;
    end else if (exp_q.size() == 0) begin
      if (bus_msb.valid_in) begin
        exp_q.push_back(bus_msb.data_in[15:8]);
        exp_q.push_back(bus_msb.data_in[7:0]);
      end
    end else if (bus_msb.ready_out) begin
      last_byte <= exp_q[0];
      exp_cnt   <= exp_cnt + 16'h0001;
      exp_q.pop_front();
      if ((exp_q.size() == 0) && bus_msb.valid_in) begin
        exp_q.push_back(bus_msb.data_in[15:8]);
        exp_q.push_back(bus_msb.data_in[7:0]);
      end
    end
  end

  always @(negedge clk) begin
    check_output("model valid_out", {31'd0, bus_msb.valid_out}, {31'd0, exp_q.size() != 0});
    check_output("model data_out", {24'd0, bus_msb.data_out},
                 {24'd0, (exp_q.size() != 0) ? exp_q[0] : last_byte});
    check_output("model ready_in", {31'd0, bus_msb.ready_in}, {31'd0, model_ready()});
`ifdef WIDTH_16TO8_BYTE_CNT_EN
    check_output("model byte_cnt", {16'd0, cnt_msb}, {16'd0, exp_cnt});
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [15:0] word);
    bus_msb.valid_in = 1'b1;
    bus_msb.data_in  = word;
  endtask

  // Streams up to three words through dut_msb, capturing what each cycle shows.
  logic [7:0]  cap_data[8];
  logic        cap_rdy[8];
  logic [15:0] cap_cnt[8];

  task automatic run_words(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                           input int n_words, input int n_cyc);
    logic [15:0] words[3];
    int k;
    logic pend;
    words[0] = w0;
    words[1] = w1;
    words[2] = w2;
    k = 0;
    apply_stimulus(words[0]);
    pend = bus_msb.ready_in && bus_msb.valid_in;
    for (int c = 0; c < n_cyc; c++) begin
      tick();
      if (pend) begin
        k++;
        if (k < n_words) apply_stimulus(words[k]);
        else bus_msb.valid_in = 1'b0;
      end
      cap_data[c] = bus_msb.data_out;
      cap_rdy[c]  = bus_msb.ready_in;
`ifdef WIDTH_16TO8_BYTE_CNT_EN
      cap_cnt[c]  = cnt_msb;
`else
      cap_cnt[c]  = 16'h0000;
`endif
      pend = bus_msb.ready_in && bus_msb.valid_in;
    end
    bus_msb.valid_in = 1'b0;
  endtask

`ifdef WIDTH_16TO8_BYTE_CNT_EN
  task automatic stream_words(input int n);
    int acc;
    int budget;
    logic pend;
    acc    = 0;
    budget = 0;
    apply_stimulus(16'h0000);
    while (acc < n && budget < 4 * n) begin
      pend = bus_msb.ready_in && bus_msb.valid_in;
      tick();
      budget++;
      if (pend) begin
        acc++;
        apply_stimulus(acc[15:0] * 16'd3);
      end
    end
    bus_msb.valid_in = 1'b0;
    check_output("stream words accepted", acc, n);
  endtask
`endif

  logic [7:0] b2b_data[6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
  logic       b2b_rdy[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n             = 1'b1;
    bus_msb.valid_in  = 1'b0;
    bus_msb.data_in   = 16'h0000;
    bus_msb.ready_out = 1'b0;
    bus_lsb.valid_in  = 1'b0;
    bus_lsb.data_in   = 16'h0000;
    bus_lsb.ready_out = 1'b0;

    repeat (2) tick();
    check_output("reset valid_out", {31'd0, bus_msb.valid_out}, 32'd0);
    check_output("reset data_out", {24'd0, bus_msb.data_out}, 32'h00);
    check_output("reset ready_in", {31'd0, bus_msb.ready_in}, 32'd0);
    #1 rst_n = 1'b0;
    bus_msb.ready_out = 1'b1;
    bus_lsb.ready_out = 1'b1;
    #1 check_output("release ready_in", {31'd0, bus_msb.ready_in}, 32'd1);

    $display("[TB] single word 16'hA55A");
    apply_stimulus(16'hA55A);
    tick();
    bus_msb.valid_in = 1'b0;
    check_output("single first byte", {24'd0, bus_msb.data_out}, 32'hA5);
    check_output("single first valid", {31'd0, bus_msb.valid_out}, 32'd1);
    check_output("single first ready_in", {31'd0, bus_msb.ready_in}, 32'd0);
    tick();
    check_output("single second byte", {24'd0, bus_msb.data_out}, 32'h5A);
    check_output("single second ready_in", {31'd0, bus_msb.ready_in}, 32'd1);
    tick();
    check_output("single idle valid", {31'd0, bus_msb.valid_out}, 32'd0);
    check_output("single idle data", {24'd0, bus_msb.data_out}, 32'h5A);
    check_output("single idle ready_in", {31'd0, bus_msb.ready_in}, 32'd1);

    $display("[TB] back-to-back words");
    run_words(16'h1234, 16'h5678, 16'h9ABC, 3, 6);
    for (int c = 0; c < 6; c++) begin
      check_output($sformatf("b2b data[%0d]", c), {24'd0, cap_data[c]}, {24'd0, b2b_data[c]});
      check_output($sformatf("b2b ready_in[%0d]", c), {31'd0, cap_rdy[c]}, {31'd0, b2b_rdy[c]});
    end
    tick();
    check_output("b2b idle valid", {31'd0, bus_msb.valid_out}, 32'd0);

    $display("[TB] backpressure 16'hBEEF");
    apply_stimulus(16'hBEEF);
    bus_msb.ready_out = 1'b0;
    tick();
    bus_msb.valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("stall data[%0d]", i), {24'd0, bus_msb.data_out}, 32'hBE);
      check_output($sformatf("stall valid[%0d]", i), {31'd0, bus_msb.valid_out}, 32'd1);
      check_output($sformatf("stall ready_in[%0d]", i), {31'd0, bus_msb.ready_in}, 32'd0);
      if (i < 2) tick();
    end
    bus_msb.ready_out = 1'b1;
    tick();
    check_output("stall release byte", {24'd0, bus_msb.data_out}, 32'hEF);
    tick();

    $display("[TB] LSB-first 16'hC3D4");
    bus_lsb.valid_in = 1'b1;
    bus_lsb.data_in  = 16'hC3D4;
    tick();
    bus_lsb.valid_in = 1'b0;
    check_output("lsb first byte", {24'd0, bus_lsb.data_out}, 32'hD4);
    tick();
    check_output("lsb second byte", {24'd0, bus_lsb.data_out}, 32'hC3);
    check_output("lsb second valid", {31'd0, bus_lsb.valid_out}, 32'd1);
    tick();
    check_output("lsb idle valid", {31'd0, bus_lsb.valid_out}, 32'd0);
`ifdef WIDTH_16TO8_BYTE_CNT_EN
    check_output("lsb byte_cnt", {16'd0, cnt_lsb}, 32'd2);
`endif

    $display("[TB] reset mid-word 16'h0F0E");
    apply_stimulus(16'h0F0E);
    tick();
    bus_msb.valid_in  = 1'b0;
    bus_msb.ready_out = 1'b0;
    check_output("pre-reset byte", {24'd0, bus_msb.data_out}, 32'h0F);
    #1 rst_n = 1'b1;
    #1;
    check_output("async reset valid", {31'd0, bus_msb.valid_out}, 32'd0);
    check_output("async reset data", {24'd0, bus_msb.data_out}, 32'h00);
    check_output("async reset ready_in", {31'd0, bus_msb.ready_in}, 32'd0);
    tick();
    check_output("held reset ready_in", {31'd0, bus_msb.ready_in}, 32'd0);
    #1 rst_n = 1'b0;
    bus_msb.ready_out = 1'b1;
    #1 check_output("post-reset ready_in", {31'd0, bus_msb.ready_in}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_output($sformatf("no stale byte valid[%0d]", i), {31'd0, bus_msb.valid_out}, 32'd0);
      check_output($sformatf("no stale byte data[%0d]", i), {24'd0, bus_msb.data_out}, 32'h00);
    end

`ifdef WIDTH_16TO8_BYTE_CNT_EN
    $display("[TB] byte counter wrap");
    stream_words(32767);
    repeat (3) tick();
    check_output("preload byte_cnt", {16'd0, cnt_msb}, 32'hFFFE);
    run_words(16'h1122, 16'h3344, 16'h0000, 2, 5);
    check_output("wrap cnt[0]", {16'd0, cap_cnt[0]}, 32'hFFFE);
    check_output("wrap cnt[1]", {16'd0, cap_cnt[1]}, 32'hFFFF);
    check_output("wrap cnt[2]", {16'd0, cap_cnt[2]}, 32'h0000);
    check_output("wrap cnt[3]", {16'd0, cap_cnt[3]}, 32'h0001);
    check_output("wrap cnt[4]", {16'd0, cap_cnt[4]}, 32'h0002);
    check_output("wrap last byte", {24'd0, cap_data[3]}, 32'h44);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/width_16to8.md
Name: width_16to8

Overview:
- Serialiser and the reverse of the 8-to-16 width converter: accepts one 16-bit word per handshake and emits it as two 8-bit beats.
- Sits on the downstream side of 16-bit datapaths feeding byte-wide consumers.
- Valid/ready on both sides; sustains full output rate, one word every 2 cycles with no bubble.

Parameters:
- MSB_FIRST, 1, 1 = high byte data_in[15:8] sent first; 0 = low byte data_in[7:0] first.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-high (block held in reset while rst_n = 1).
- valid_in  input  1  upstream word valid.
- data_in  input  16  upstream word.
- ready_in  output  1  block can accept a word this cycle; combinational from state and ready_out.
- valid_out  output  1  byte valid; registered.
- data_out  output  8  byte; registered.
- ready_out  input  1  downstream accepts the byte this cycle.

Behaviour:
- Handshakes:
  - Input transfer = valid_in && ready_in at a rising edge.
  - Output transfer = valid_out && ready_out at a rising edge.
- Reset:
  - state = IDLE, valid_out = 0, data_out = 8'h00, internal second-byte register = 8'h00.
  - ready_in is forced 0 while rst_n = 1.
  - Reset mid-word discards any unsent byte; no beat is emitted after reset release until a new input transfer.
- Byte order: first = MSB_FIRST ? data_in[15:8] : data_in[7:0]; second = the other byte, held in an 8-bit register.
- State IDLE:
  - valid_out = 0; ready_in = 1.
  - On input transfer: data_out <= first, second_reg <= second, valid_out <= 1, -> FIRST.
- State FIRST:
  - valid_out = 1; ready_in = 0.
  - On ready_out: data_out <= second_reg, -> SECOND.
  - Otherwise data_out and valid_out hold.
- State SECOND:
  - valid_out = 1; ready_in = ready_out.
  - ready_out && valid_in: load the new word as in IDLE, -> FIRST. Back-to-back, no gap cycle.
  - ready_out && !valid_in: valid_out <= 0, -> IDLE; data_out keeps the last byte.
  - !ready_out: hold everything.
- Latency: word accepted at edge N -> first byte valid from edge N; second byte valid from the edge after the first byte's output transfer.
- Data stability: data_out and valid_out never change while valid_out = 1 && ready_out = 0.
- data_in is sampled only at an input transfer; changes at any other time are ignored.
- Unused 2-bit state encoding is illegal; it recovers to IDLE on the next edge with valid_out <= 0.
- No combinational path from valid_in to valid_out or data_out. The only combinational path is ready_out -> ready_in.

Optional Feature:
- Macro WIDTH_16TO8_BYTE_CNT_EN.
- Defined:
  - Extra output port byte_cnt [15:0], registered, reset 16'h0000.
  - Increments by 1 on every output transfer; wraps 16'hFFFF -> 16'h0000.
  - Cleared asynchronously by rst_n.
- Undefined: port and counter logic absent; all other behaviour identical.

Test Plan:
- Single word, MSB_FIRST=1, ready_out=1:
  - Stimulus: 16'hA55A.
  - Response: data_out 8'hA5 then 8'h5A on consecutive cycles with valid_out=1; then valid_out=0, data_out stays 8'h5A, ready_in=1.
- Back-to-back words, ready_out=1:
  - Stimulus: 16'h1234, 16'h5678, 16'h9ABC held valid.
  - Response: bytes 12,34,56,78,9A,BC on 6 consecutive cycles with no gaps; ready_in high only in the cycles showing 34, 78, BC.
- Backpressure:
  - Stimulus: word 16'hBEEF; ready_out=0 for 3 cycles while 8'hBE is shown; then ready_out=1.
  - Response: data_out holds 8'hBE and valid_out holds 1 for those 3 cycles, then 8'hEF; ready_in=0 throughout FIRST.
- MSB_FIRST=0:
  - Stimulus: 16'hC3D4.
  - Response: 8'hD4 then 8'hC3.
- Reset mid-word:
  - Stimulus: word 16'h0F0E; rst_n=1 asserted asynchronously while 8'h0F is shown.
  - Response: valid_out=0 and data_out=8'h00 immediately; 8'h0E never emitted; ready_in=0 during reset, 1 after release.
- Byte counter (WIDTH_16TO8_BYTE_CNT_EN):
  - Stimulus: preload via 65534 output transfers, then send 2 more words.
  - Response: byte_cnt runs 16'hFFFE -> 16'hFFFF -> 16'h0000 -> 16'h0001 -> 16'h0002.
